// File: rtl/window_buffer.sv
// window_buffer: takes KxDW pixel columns from the line buffer, where slices
// arrive in physical line order. It rotates each column into top-to-bottom
// order and slides a KxK window across each window-row. It presents one
// window per accepted column once K columns of the current row are present.
module window_buffer #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 5,
   parameter int DW    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [K*DW-1:0]   col_data,
   input  logic              valid_line_win,
   output logic              ready_win,
   output logic [K*K*DW-1:0] window,
   output logic              valid_win,
   input  logic              ready_conv,
   output logic              last_win
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int PW = (K > 1) ? $clog2(K) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_FULL = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - K);
   localparam logic [PW-1:0] PH_LAST  = PW'(K - 1);

   logic [CW-1:0] col_cnt;     // column index within the current image row
   logic [RW-1:0] row_cnt;     // current window-row, 0..IMG_H-K
   logic [PW-1:0] row_phase;   // row_cnt mod K, kept as its own wrapping counter
   logic [DW-1:0] win_q   [K][K];  // [logical row][column], column 0 oldest
   logic [DW-1:0] col_ord [K];     // incoming column in logical row order
   logic          acc;
   logic          col_wrap;

   // The single output stage may take a new column when empty or being drained.
   assign ready_win = !valid_win || ready_conv;
   assign acc       = valid_line_win && ready_win;
   assign col_wrap  = (col_cnt == COL_LAST);

   // Rotate physical slices so that logical row k takes slice (phase + k) mod K.
   always_comb begin : reorder
      int sel;
      // NOTE: combinational outputs get a default before any loop or branch, so no latch can be inferred.
      sel = 0;
      for (int k = 0; k < K; k++) col_ord[k] = '0;
      for (int k = 0; k < K; k++) begin
         sel = int'(row_phase) + k;
         if (sel >= K) sel = sel - K;
         col_ord[k] = col_data[sel*DW +: DW];
      end
   end

   // Flatten the window array onto the output bus, row-major, top-left at bit 0.
   always_comb begin
      window = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            window[(r*K + c)*DW +: DW] = win_q[r][c];
         end
      end
   end

   // Shift register, position counters and output handshake state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_cnt   <= '0;
         row_cnt   <= '0;
         row_phase <= '0;
         valid_win <= 1'b0;
         last_win  <= 1'b0;
         // NOTE: the window array is reset because it drives the output port directly and must read as zero after reset.
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) win_q[r][c] <= '0;
         end
      end else if (acc) begin
         // NOTE: non-blocking assignments let every column read its neighbour's old value on the same edge.
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) win_q[r][c] <= win_q[r][c+1];
            win_q[r][K-1] <= col_ord[r];
         end
         // The first K-1 columns of each row only fill the window.
         valid_win <= (col_cnt >= COL_FULL);
         last_win  <= col_wrap && (row_cnt == ROW_LAST);
         if (col_wrap) begin
            col_cnt <= '0;
            if (row_cnt == ROW_LAST) begin
               row_cnt   <= '0;
               row_phase <= '0;
            end else begin
               row_cnt   <= row_cnt + RW'(1);
               row_phase <= (row_phase == PH_LAST) ? '0 : row_phase + PW'(1);
            end
         end else begin
            col_cnt <= col_cnt + CW'(1);
         end
      end else if (ready_conv) begin
         valid_win <= 1'b0;
         last_win  <= 1'b0;
      end
   end

endmodule

// File: doc/window_buffer.md
Name: window_buffer

Overview:
- Downstream neighbour of the 5-row line buffer.
- Consumes 5x1 pixel columns from it, which arrive in physical line order (line index = y mod 5), and reorders each column into logical top-to-bottom order.
- Keeps a 5x5 sliding window in a column shift register and presents each valid 5x5 window to the convolution engine.
- Per 28x28 frame: 24 rows x 24 windows = 576 windows, each with a ready/valid handshake.

Parameters:
- IMG_W, 28, input image width in pixels
- IMG_H, 28, input image height in pixels
- K, 5, kernel size (window is K x K)
- DW, 8, pixel width in bits

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- col_data  input  K*DW  column from line buffer; slice i = physical line i
- valid_line_win  input  1  col_data valid
- ready_win  output  1  block can accept a column this cycle
- window  output  K*K*DW  window; pixel (row r, col c) at bits [(r*K+c)*DW +: DW]; r=0 top, c=0 leftmost/oldest
- valid_win  output  1  window valid
- ready_conv  input  1  convolution engine accepts window
- last_win  output  1  qualifies the final window of a frame (row IMG_H-K, col IMG_W-K)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - valid_win=0, last_win=0, window=0.
  - col_cnt=0, row_cnt=0, shift register cleared.
  - ready_win is combinational, so it is 1 during reset.
  - Reset mid-frame discards all partial state; the next accepted column is treated as column 0 of window-row 0.
- ready_win = !valid_win | ready_conv, combinational. Single-stage output, no skid buffer.
- Accept: acc = valid_line_win & ready_win. Window output is released when valid_win & ready_conv.
- Row reordering at accept:
  - Logical row k takes physical slice (row_cnt + k) mod K.
  - row_cnt is the current window-row index, 0..IMG_H-K.
  - Use a counter that wraps at K, not a divider.
- Shift on acc:
  - Columns 0..K-2 take columns 1..K-1.
  - Column K-1 takes the reordered input column.
- col_cnt, 0..IMG_W-1, on acc:
  - If col_cnt == IMG_W-1: col_cnt <= 0 and row_cnt advances.
  - row_cnt advances as row_cnt == IMG_H-K ? 0 : row_cnt+1.
  - Otherwise: col_cnt+1.
  - The row-phase counter (row_cnt mod K) advances with row_cnt and resets to 0 when row_cnt wraps.
- valid_win, next state:
  - If acc: valid_win <= (col_cnt >= K-1). This uses the pre-increment col_cnt.
  - Else if ready_conv: valid_win <= 0.
  - Else: hold.
  - The first K-1 columns of each row produce no window. Window fill restarts every row; no window ever spans a row boundary.
- Window register updates only on acc. While valid_win & !ready_conv, window, last_win and the internal state hold stable.
- last_win <= acc & (col_cnt == IMG_W-1) & (row_cnt == IMG_H-K). It updates and holds with valid_win.
- Latency: 1 cycle from accepted column to valid_win.
- Throughput: 1 window/cycle when ready_conv is held high.
- Simultaneous accept and output consume in one cycle: the new window replaces the old; no bubble.
- Backpressure: ready_conv=0 with valid_win=1 forces ready_win=0 in the same cycle, so no columns are lost.
- Arithmetic: counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide, compared against parameter constants. No modulo on data paths.

Test Plan:
- Reset then continuous stream of 28x28 columns; col_data slice i = {line i, x}; ready_conv=1.
  - Exactly 576 windows.
  - First window one cycle after the 5th column.
  - window(0,0)=pixel(0,0), window(4,4)=pixel(4,4).
  - last_win=1 only on window 576.
- Row reorder check at row_cnt=2 (physical order lines 2,3,4,0,1).
  - window row 0 = physical slice 2; row 4 = slice 1.
  - Compare against a golden 28x28 image model.
- Backpressure: ready_conv=0 for 10 cycles mid-row with valid_line_win=1.
  - ready_win=0 throughout; window held bit-stable.
  - On release the next window is column+1; no pixels skipped or duplicated.
- Row boundary: accept col 27 then col 0 of the next row.
  - valid_win drops after the col-27 window is consumed.
  - No window is produced for the next row until 5 new columns are accepted.
- Sparse input: valid_line_win toggles 1-0-1 with random ready_conv.
  - Window sequence matches the golden model.
  - valid_win never asserts without a preceding accept.
- Reset asserted at row 10, col 15, then a new frame.
  - Outputs 0 immediately after reset.
  - The new frame's first window equals golden window(0,0).
